// File: rtl/mem_stage.sv
// MEM stage with MEM/WB register: fixed-latency data-memory access that stalls upstream while busy.
// Optional MEM_MISALIGN_TRAP_EN: misaligned memory ops complete at once with Exception_Out=1.
module mem_stage #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Valid_In,
  input  logic [31:0] Address_In,
  input  logic [31:0] WriteData_In,
  input  logic [1:0]  MemControl_In,
  input  logic [1:0]  WBControl_In,
  input  logic [4:0]  WriteReg_In,
  output logic        Stall_Out,
  output logic        Valid_Out,
  output logic [31:0] Address_Out,
  output logic [31:0] ReadData_Out,
  output logic [1:0]  WBControl_Out,
  output logic [4:0]  WriteReg_Out,
  output logic        Exception_Out
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic [31:0] h_addr, h_wdata;
  logic [1:0]  h_mc, h_wb;
  logic [4:0]  h_wreg;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] idx;

  logic accept, misalign, start_mem, done;

  assign accept = (state == IDLE) && Valid_In;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = accept && (|MemControl_In) && (|Address_In[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign start_mem = accept && (|MemControl_In) && !misalign;
  assign done      = (state == WAIT) && (cnt == 4'd0);
  assign idx       = h_addr[ADDR_WIDTH+1:2];
  assign Stall_Out = (state == WAIT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (start_mem) begin
        state_nxt = WAIT;
        cnt_nxt   = 4'(MEM_LATENCY - 1);
      end
      WAIT: if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      h_addr  <= '0;
      h_wdata <= '0;
      h_mc    <= '0;
      h_wb    <= '0;
      h_wreg  <= '0;
    end else if (accept) begin
      h_addr  <= Address_In;
      h_wdata <= WriteData_In;
      h_mc    <= MemControl_In;
      h_wb    <= WBControl_In;
      h_wreg  <= WriteReg_In;
    end
  end

  // No reset on the array; reset forces IDLE asynchronously, so an in-flight store never reaches done.
  always_ff @(posedge Clk) begin
    if (done && h_mc[0]) mem[idx] <= h_wdata;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Valid_Out     <= 1'b0;
      Address_Out   <= '0;
      ReadData_Out  <= '0;
      WBControl_Out <= '0;
      WriteReg_Out  <= '0;
    end else if (accept && !start_mem) begin
      Valid_Out     <= 1'b1;
      Address_Out   <= Address_In;
      ReadData_Out  <= '0;
      WBControl_Out <= misalign ? 2'b00 : WBControl_In;
      WriteReg_Out  <= WriteReg_In;
    end else if (done) begin
      // Read happens before the same-edge write, so MemControl=11 returns the old word.
      Valid_Out     <= 1'b1;
      Address_Out   <= h_addr;
      ReadData_Out  <= h_mc[1] ? mem[idx] : 32'd0;
      WBControl_Out <= h_wb;
      WriteReg_Out  <= h_wreg;
    end else begin
      Valid_Out     <= 1'b0;
      WBControl_Out <= 2'b00;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic exc_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) exc_q <= 1'b0;
    else          exc_q <= misalign;
  end
  assign Exception_Out = exc_q;
`else
  assign Exception_Out = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a word-array model predicts each completion,
// a negedge monitor pops and compares whenever Valid_Out is high.
module tb_mem_stage;
  localparam int MEM_LATENCY = 2;
  localparam int ADDR_WIDTH  = 8;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        Valid_In = 1'b0;
  logic [31:0] Address_In = '0, WriteData_In = '0;
  logic [1:0]  MemControl_In = '0, WBControl_In = '0;
  logic [4:0]  WriteReg_In = '0;
  logic        Stall_Out, Valid_Out, Exception_Out;
  logic [31:0] Address_Out, ReadData_Out;
  logic [1:0]  WBControl_Out;
  logic [4:0]  WriteReg_Out;

  mem_stage #(.MEM_LATENCY(MEM_LATENCY), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Valid_In(Valid_In), .Address_In(Address_In),
    .WriteData_In(WriteData_In), .MemControl_In(MemControl_In), .WBControl_In(WBControl_In),
    .WriteReg_In(WriteReg_In), .Stall_Out(Stall_Out), .Valid_Out(Valid_Out),
    .Address_Out(Address_Out), .ReadData_Out(ReadData_Out), .WBControl_Out(WBControl_Out),
    .WriteReg_Out(WriteReg_Out), .Exception_Out(Exception_Out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  wb;
    logic [4:0]  wreg;
    logic        exc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [0:(1<<ADDR_WIDTH)-1];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks reset values, bubbles, and every completion against the scoreboard.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      chk("rst_stall", 32'(Stall_Out), 32'd0);
      chk("rst_valid", 32'(Valid_Out), 32'd0);
      chk("rst_addr",  Address_Out, 32'd0);
      chk("rst_rdata", ReadData_Out, 32'd0);
      chk("rst_wb",    32'(WBControl_Out), 32'd0);
      chk("rst_wreg",  32'(WriteReg_Out), 32'd0);
      chk("rst_exc",   32'(Exception_Out), 32'd0);
    end else if (Valid_Out) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("addr",  Address_Out, e.addr);
        chk("rdata", ReadData_Out, e.rdata);
        chk("wb",    32'(WBControl_Out), 32'(e.wb));
        chk("wreg",  32'(WriteReg_Out), 32'(e.wreg));
        chk("exc",   32'(Exception_Out), 32'(e.exc));
      end
    end else begin
      chk("bubble_wb", 32'(WBControl_Out), 32'd0);
    end
  end

  // Present one instruction (DUT is known idle), predict its result, check the stall window.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] mc,
                       input logic [1:0] wb, input logic [4:0] wr);
    exp_t e;
    bit trap, memop;
    int widx;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (mc != 2'b00) && (a[1:0] != 2'b00);
`endif
    memop = (mc != 2'b00) && !trap;
    widx  = int'(a[ADDR_WIDTH+1:2]);
    e.addr  = a;
    e.wreg  = wr;
    e.exc   = trap;
    e.wb    = trap ? 2'b00 : wb;
    e.rdata = (memop && mc[1]) ? model_mem[widx] : 32'd0;
    if (memop && mc[0]) model_mem[widx] = d;
    chk("stall_before_accept", 32'(Stall_Out), 32'd0);
    Valid_In = 1'b1; Address_In = a; WriteData_In = d;
    MemControl_In = mc; WBControl_In = wb; WriteReg_In = wr;
    sb.push_back(e);
    @(posedge Clk); #1;
    Valid_In = 1'b0; Address_In = $urandom; WriteData_In = $urandom;
    MemControl_In = 2'($urandom); WBControl_In = 2'($urandom); WriteReg_In = 5'($urandom);
    if (memop) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        chk("stall_high", 32'(Stall_Out), 32'd1);
        @(posedge Clk); #1;
      end
    end
    chk("stall_low", 32'(Stall_Out), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      Valid_In = 1'b0; WBControl_In = 2'b11; MemControl_In = 2'($urandom);
      @(posedge Clk); #1;
    end
  endtask

  initial begin
    #2 Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Pass-through after reset, then a couple of back-to-back non-memory ops.
    issue(32'h1, 32'h0, 2'b00, 2'b11, 5'd5);
    issue(32'h8, 32'h0, 2'b00, 2'b10, 5'd6);
    issue(32'hFFFF_FFFC, 32'h0, 2'b00, 2'b01, 5'd31);
    idle(2);

    // Give every word a known value so random loads are defined.
    for (int w = 0; w < (1 << ADDR_WIDTH); w++)
      issue(32'(w) << 2, $urandom, 2'b01, 2'($urandom), 5'($urandom));

    issue(32'h10, 32'hDEADBEEF, 2'b01, 2'b00, 5'd0);
    issue(32'h10, 32'h0, 2'b10, 2'b11, 5'd7);
    issue(32'h400, 32'h12345678, 2'b01, 2'b00, 5'd0);
    issue(32'h000, 32'h0, 2'b10, 2'b11, 5'd8);
    idle(3);
    issue(32'h40, 32'd7, 2'b01, 2'b00, 5'd0);
    issue(32'h40, 32'd9, 2'b11, 2'b11, 5'd9);
    issue(32'h40, 32'h0, 2'b10, 2'b11, 5'd10);
    issue(32'h13, 32'hCAFEF00D, 2'b01, 2'b11, 5'd3);
    issue(32'h10, 32'h0, 2'b10, 2'b11, 5'd4);

    // Reset while a store waits: the store must be lost.
    issue(32'h20, 32'h11111111, 2'b01, 2'b00, 5'd0);
    idle(2);
    Valid_In = 1'b1; Address_In = 32'h20; WriteData_In = 32'hAAAAAAAA;
    MemControl_In = 2'b01; WBControl_In = 2'b00; WriteReg_In = 5'd0;
    @(posedge Clk); #1;
    Valid_In = 1'b0;
    chk("stall_before_reset", 32'(Stall_Out), 32'd1);
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    issue(32'h20, 32'h0, 2'b10, 2'b11, 5'd11);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      issue(a, $urandom, 2'($urandom), 2'($urandom), 5'($urandom));
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge Clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
